// File: rtl/alu_control_seq_if.sv
// Decode request / control result bundle between main control, the ALU control stage and the ID/EX side.
// The slave modport is the ALU control stage; the master modport is its environment.
interface alu_control_seq_if #(
  parameter int ALU_OP_WIDTH  = 3,
  parameter int FUNCT_WIDTH   = 6,
  parameter int ALU_CTL_WIDTH = 4
);
  logic                     valid_i;
  logic                     flush_i;
  logic [ALU_OP_WIDTH-1:0]  alu_op_i;
  logic [FUNCT_WIDTH-1:0]   alu_function_i;
  logic                     valid_o;
  logic [ALU_CTL_WIDTH-1:0] alu_operation_o;
  logic [1:0]               jmp_ctl_o;
  logic [1:0]               hilo_sel_o;
  logic                     muldiv_start_o;
  logic                     muldiv_is_div_o;
  logic                     hilo_we_o;
  logic                     stall_o;
  logic                     illegal_o;

  modport slave (
    input  valid_i, flush_i, alu_op_i, alu_function_i,
    output valid_o, alu_operation_o, jmp_ctl_o, hilo_sel_o, muldiv_start_o,
           muldiv_is_div_o, hilo_we_o, stall_o, illegal_o
  );

  modport master (
    output valid_i, flush_i, alu_op_i, alu_function_i,
    input  valid_o, alu_operation_o, jmp_ctl_o, hilo_sel_o, muldiv_start_o,
           muldiv_is_div_o, hilo_we_o, stall_o, illegal_o
  );
endinterface

// File: rtl/alu_control_seq.sv
// ALU control decode with a one-cycle registered output stage; stalls upstream while MULT/DIV runs.
// Latency 1 cycle; inputs are ignored (not queued) whenever stall_o is high.
module alu_control_seq #(
  parameter int ALU_OP_WIDTH  = 3,
  parameter int FUNCT_WIDTH   = 6,
  parameter int ALU_CTL_WIDTH = 4,
  parameter int MULT_CYCLES   = 4,
  parameter int DIV_CYCLES    = 8
) (
  input logic              clk,
  input logic              reset,
  alu_control_seq_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic [ALU_CTL_WIDTH-1:0] op_q, op_d;
  logic [1:0]               jmp_q, jmp_d;
  logic [1:0]               hsel_q, hsel_d;
  logic                     start_q, start_d;
  logic                     is_div_q, is_div_d;
  logic                     illegal_q, illegal_d;

  logic [ALU_CTL_WIDTH-1:0] dec_op;
  logic [1:0]               dec_jmp, dec_hsel;
  logic                     dec_illegal, dec_md, dec_div;
  logic                     stall, accept;

  always_comb begin
    dec_op      = '0;
    dec_jmp     = 2'b00;
    dec_hsel    = 2'b00;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    dec_div     = 1'b0;
    case (bus.alu_op_i)
      ALU_OP_WIDTH'(7): begin
        case (bus.alu_function_i)
          FUNCT_WIDTH'(6'b100000): dec_op = ALU_CTL_WIDTH'(4'b0011);
          FUNCT_WIDTH'(6'b100010): dec_op = ALU_CTL_WIDTH'(4'b0100);
          FUNCT_WIDTH'(6'b100100): dec_op = ALU_CTL_WIDTH'(4'b0110);
          FUNCT_WIDTH'(6'b100101): dec_op = ALU_CTL_WIDTH'(4'b0010);
          FUNCT_WIDTH'(6'b100111): dec_op = ALU_CTL_WIDTH'(4'b0111);
          FUNCT_WIDTH'(6'b001000): begin
            dec_op  = ALU_CTL_WIDTH'(4'b1001);
            dec_jmp = 2'b10;
          end
          FUNCT_WIDTH'(6'b000000): dec_op = ALU_CTL_WIDTH'(4'b1010);
          FUNCT_WIDTH'(6'b000010): dec_op = ALU_CTL_WIDTH'(4'b1011);
          FUNCT_WIDTH'(6'b101010): dec_op = ALU_CTL_WIDTH'(4'b1100);
          FUNCT_WIDTH'(6'b011000): begin
            dec_op = ALU_CTL_WIDTH'(4'b1101);
            dec_md = 1'b1;
          end
          FUNCT_WIDTH'(6'b011010): begin
            dec_op  = ALU_CTL_WIDTH'(4'b1110);
            dec_md  = 1'b1;
            dec_div = 1'b1;
          end
          FUNCT_WIDTH'(6'b010000): dec_hsel = 2'b01;
          FUNCT_WIDTH'(6'b010010): dec_hsel = 2'b10;
          default:                 dec_illegal = 1'b1;
        endcase
      end
      ALU_OP_WIDTH'(4): dec_op = ALU_CTL_WIDTH'(4'b0011);
      ALU_OP_WIDTH'(5): dec_op = ALU_CTL_WIDTH'(4'b0010);
      ALU_OP_WIDTH'(1): dec_op = ALU_CTL_WIDTH'(4'b0110);
      ALU_OP_WIDTH'(6): dec_op = ALU_CTL_WIDTH'(4'b0101);
      ALU_OP_WIDTH'(3): dec_op = ALU_CTL_WIDTH'(4'b0011);
      ALU_OP_WIDTH'(2): dec_op = ALU_CTL_WIDTH'(4'b0100);
      default:          dec_illegal = 1'b1;
    endcase
  end

  // Reset drops stall and the HI/LO commit in the same cycle, so an abandoned op never writes.
  assign stall  = (state_q == BUSY) && !reset;
  assign accept = bus.valid_i && !stall && !bus.flush_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    op_d      = '0;
    jmp_d     = 2'b00;
    hsel_d    = 2'b00;
    start_d   = 1'b0;
    is_div_d  = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          valid_d   = 1'b1;
          op_d      = dec_op;
          jmp_d     = dec_jmp;
          hsel_d    = dec_hsel;
          illegal_d = dec_illegal;
          if (dec_md) begin
            start_d  = 1'b1;
            is_div_d = dec_div;
            state_d  = BUSY;
            cnt_d    = dec_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      op_q      <= '0;
      jmp_q     <= 2'b00;
      hsel_q    <= 2'b00;
      start_q   <= 1'b0;
      is_div_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      jmp_q     <= jmp_d;
      hsel_q    <= hsel_d;
      start_q   <= start_d;
      is_div_q  <= is_div_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.valid_o         = valid_q;
  assign bus.alu_operation_o = op_q;
  assign bus.jmp_ctl_o       = jmp_q;
  assign bus.hilo_sel_o      = hsel_q;
  assign bus.muldiv_start_o  = start_q;
  assign bus.muldiv_is_div_o = is_div_q;
  assign bus.hilo_we_o       = stall && (cnt_q == '0);
  assign bus.stall_o         = stall;
  assign bus.illegal_o       = illegal_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: two instances (4/8-cycle and 1/1-cycle MULT/DIV) share one stimulus stream
// and are compared every cycle against a stall-countdown reference model.
module tb_alu_control_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_control_seq_if bus0 ();
  alu_control_seq_if bus1 ();

  alu_control_seq #(.MULT_CYCLES(4), .DIV_CYCLES(8)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
  alu_control_seq #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  int          busy_left [2];
  int          mult_cyc  [2] = '{4, 1};
  int          div_cyc   [2] = '{8, 1};
  logic [10:0] exp_reg   [2];
  logic        exp_ill   [2];

  logic [8:0] tbl [22] = '{
    9'b111_100000, 9'b111_100010, 9'b111_100100, 9'b111_100101, 9'b111_100111,
    9'b111_001000, 9'b111_000000, 9'b111_000010, 9'b111_101010, 9'b111_011000,
    9'b111_011010, 9'b111_010000, 9'b111_010010,
    9'b100_000000, 9'b101_111111, 9'b001_010101, 9'b110_000000, 9'b011_100000,
    9'b010_001000, 9'b111_111111, 9'b000_100000, 9'b111_000001
  };

  // Returns {illegal, is_muldiv, is_div, alu_op[3:0], jmp[1:0], hilo_sel[1:0]}.
  function automatic logic [10:0] ref_decode(input logic [2:0] op, input logic [5:0] fn);
    logic [10:0] r;
    r = 11'b100_0000_00_00;
    if (op == 3'b111) begin
      case (fn)
        6'b100000: r = {3'b000, 4'b0011, 2'b00, 2'b00};
        6'b100010: r = {3'b000, 4'b0100, 2'b00, 2'b00};
        6'b100100: r = {3'b000, 4'b0110, 2'b00, 2'b00};
        6'b100101: r = {3'b000, 4'b0010, 2'b00, 2'b00};
        6'b100111: r = {3'b000, 4'b0111, 2'b00, 2'b00};
        6'b001000: r = {3'b000, 4'b1001, 2'b10, 2'b00};
        6'b000000: r = {3'b000, 4'b1010, 2'b00, 2'b00};
        6'b000010: r = {3'b000, 4'b1011, 2'b00, 2'b00};
        6'b101010: r = {3'b000, 4'b1100, 2'b00, 2'b00};
        6'b011000: r = {3'b010, 4'b1101, 2'b00, 2'b00};
        6'b011010: r = {3'b011, 4'b1110, 2'b00, 2'b00};
        6'b010000: r = {3'b000, 4'b0000, 2'b00, 2'b01};
        6'b010010: r = {3'b000, 4'b0000, 2'b00, 2'b10};
        default:   r = 11'b100_0000_00_00;
      endcase
    end else if (op == 3'b100 || op == 3'b011) r = {3'b000, 4'b0011, 4'b0000};
    else if (op == 3'b101) r = {3'b000, 4'b0010, 4'b0000};
    else if (op == 3'b001) r = {3'b000, 4'b0110, 4'b0000};
    else if (op == 3'b110) r = {3'b000, 4'b0101, 4'b0000};
    else if (op == 3'b010) r = {3'b000, 4'b0100, 4'b0000};
    return r;
  endfunction

  task automatic step(input logic v, input logic f, input logic [2:0] op, input logic [5:0] fn,
                      input logic r, input string tag);
    logic [10:0] d;
    logic        acc;
    logic [14:0] obs, expv;
    bus0.valid_i = v; bus0.flush_i = f; bus0.alu_op_i = op; bus0.alu_function_i = fn;
    bus1.valid_i = v; bus1.flush_i = f; bus1.alu_op_i = op; bus1.alu_function_i = fn;
    rst = r;
    @(posedge clk);
    d = ref_decode(op, fn);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        busy_left[k] = 0;
        exp_reg[k]   = '0;
        exp_ill[k]   = 1'b0;
      end else begin
        acc = v && (busy_left[k] == 0) && !f;
        if (busy_left[k] > 0) busy_left[k]--;
        exp_reg[k] = '0;
        exp_ill[k] = 1'b0;
        if (acc) begin
          exp_reg[k] = {1'b1, d[7:0], d[9], d[9] & d[8]};
          exp_ill[k] = d[10];
          if (d[9]) busy_left[k] = d[8] ? div_cyc[k] : mult_cyc[k];
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      expv = {exp_reg[k], busy_left[k] == 1, busy_left[k] > 0, exp_ill[k]};
      if (k == 0)
        obs = {bus0.valid_o, bus0.alu_operation_o, bus0.jmp_ctl_o, bus0.hilo_sel_o, bus0.muldiv_start_o,
               bus0.muldiv_is_div_o, bus0.hilo_we_o, bus0.stall_o, bus0.illegal_o};
      else
        obs = {bus1.valid_o, bus1.alu_operation_o, bus1.jmp_ctl_o, bus1.hilo_sel_o, bus1.muldiv_start_o,
               bus1.muldiv_is_div_o, bus1.hilo_we_o, bus1.stall_o, bus1.illegal_o};
      checks++;
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s dut%0d observed %b required %b", tag, k, obs, expv);
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (busy_left[0] + busy_left[1]) > 0; i++) step(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, tag);
  endtask

  initial begin
    logic [2:0] rop;
    logic [5:0] rfn;
    logic [8:0] e;
    busy_left = '{0, 0};
    exp_reg   = '{11'd0, 11'd0};
    exp_ill   = '{1'b0, 1'b0};
    step(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, "reset");
    step(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, "reset");
    step(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, "idle");

    for (int i = 0; i < 22; i++) begin
      e = tbl[i];
      step(1'b1, 1'b0, e[8:6], e[5:0], 1'b0, "table");
      drain("table_drain");
    end

    // MULT followed by a held MFHI that must wait out the busy window.
    step(1'b1, 1'b0, 3'b111, 6'b011000, 1'b0, "mult");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 3'b111, 6'b010000, 1'b0, "mfhi_held");
    drain("mult_drain");

    step(1'b1, 1'b0, 3'b111, 6'b011010, 1'b0, "div");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 3'b111, 6'b100000, 1'b0, "add_held");
    drain("div_drain");

    step(1'b1, 1'b1, 3'b111, 6'b100010, 1'b0, "flush_sub");
    step(1'b1, 1'b0, 3'b111, 6'b011000, 1'b0, "mult_flush");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'b111, 6'b100010, 1'b0, "flush_busy");
    drain("flush_drain");

    step(1'b1, 1'b0, 3'b111, 6'b011010, 1'b0, "div_rst");
    step(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, "div_busy1");
    step(1'b0, 1'b0, 3'd0, 6'd0, 1'b1, "reset_busy");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 3'd0, 6'd0, 1'b0, "after_reset");

    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        e   = tbl[$urandom_range(0, 12)];
        rfn = e[5:0];
      end else begin
        rfn = 6'($urandom);
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rop, rfn,
           $urandom_range(0, 49) == 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
